// File: rtl/debug_display_scan_if.sv
// Debug display bus: channel buses and controls in, seven-segment drive out.
// Latency/backpressure: pure wiring, no flow control on any signal.
interface debug_display_scan_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 4,
    parameter int NUM_DIGITS = 4
);
    localparam int CH_W      = $clog2(NUM_CH);
    localparam int NUM_PAGES = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS);
    localparam int PG_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [CH_W-1:0]          display_control;
    logic                     freeze;
    logic                     page_step;
    logic [6:0]               sseg_cathode;
    logic [NUM_DIGITS-1:0]    sseg_anode;
    logic                     sseg_dp;
    logic [PG_W-1:0]          cur_page;

    modport master (
        output ch_data, display_control, freeze, page_step,
        input  sseg_cathode, sseg_anode, sseg_dp, cur_page
    );

    modport slave (
        input  ch_data, display_control, freeze, page_step,
        output sseg_cathode, sseg_anode, sseg_dp, cur_page
    );
endinterface

// File: rtl/debug_display_scan.sv
// Selects one of NUM_CH buses, snapshots it and scans it (paged) onto multiplexed 7-seg digits.
// Latency: segment outputs registered one clk after scan state; data change visible within 2 clk.
// Backpressure: none; freeze holds the snapshot and channel, paging keeps working.
module debug_display_scan #(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    debug_display_scan_if.slave  bus
);
    localparam int CH_W      = $clog2(NUM_CH);
    localparam int NUM_PAGES = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS);
    localparam int PG_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int DG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W     = $clog2(REFRESH_DIV);
    localparam int NIB_TOT   = NUM_PAGES * NUM_DIGITS;
    localparam int PAD_W     = NIB_TOT * 4;

    logic [DATA_W-1:0]     snapshot;
    logic [CH_W-1:0]       ch_sel;
    logic [CH_W-1:0]       sel_eff;
    logic [PG_W-1:0]       page;
    logic [CNT_W-1:0]      cnt;
    logic [DG_W-1:0]       digit;
    logic                  step_q;
    logic [DATA_W-1:0]     ch_mux;
    logic [PAD_W-1:0]      padded;
    logic [3:0]            nibble;
    logic [6:0]            seg;
    logic                  blank_now;
    logic [6:0]            cathode_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic                  dp_q;
    int                    idx;

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        sel_eff = '0;
        if ({1'b0, bus.display_control} < (CH_W+1)'(NUM_CH))
            sel_eff = bus.display_control;
    end

    always_comb begin
        ch_mux = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (sel_eff == CH_W'(k))
                ch_mux = bus.ch_data[k*DATA_W +: DATA_W];
    end

    // Zero-extending the snapshot pads a partial last page with 0 nibbles.
    always_comb begin
        padded = PAD_W'(snapshot);
        idx    = int'(page) * NUM_DIGITS + int'(digit);
        nibble = '0;
        for (int i = 0; i < NIB_TOT; i++)
            if (idx == i)
                nibble = padded[i*4 +: 4];
    end

    always_comb begin
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

    assign blank_now = (cnt < CNT_W'(BLANK));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snapshot  <= '0;
            ch_sel    <= '0;
            page      <= '0;
            cnt       <= '0;
            digit     <= '0;
            step_q    <= 1'b0;
            cathode_q <= 7'h7F;
            anode_q   <= '1;
            dp_q      <= 1'b1;
        end else begin
            if (!bus.freeze) begin
                ch_sel   <= sel_eff;
                snapshot <= ch_mux;
            end

            step_q <= bus.page_step;
            // A channel switch restarts paging and beats a coincident step edge.
            if (!bus.freeze && (sel_eff != ch_sel))
                page <= '0;
            else if (bus.page_step && !step_q)
                page <= (page == PG_W'(NUM_PAGES-1)) ? '0 : page + 1'b1;

            if (cnt == CNT_W'(REFRESH_DIV-1)) begin
                cnt   <= '0;
                digit <= (digit == DG_W'(NUM_DIGITS-1)) ? '0 : digit + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (blank_now) begin
                anode_q   <= '1;
                cathode_q <= 7'h7F;
            end else begin
                anode_q   <= ~(NUM_DIGITS'(1) << digit);
                cathode_q <= seg;
            end
            dp_q <= !(bus.freeze && (digit == DG_W'(NUM_DIGITS-1)) && !blank_now);
        end
    end

    assign bus.sseg_cathode = cathode_q;
    assign bus.sseg_anode   = anode_q;
    assign bus.sseg_dp      = dp_q;
    assign bus.cur_page     = page;
endmodule

// File: tb/tb_debug_display_scan.sv
module tb_debug_display_scan;
    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    debug_display_scan_if #(.DATA_W(32), .NUM_CH(4), .NUM_DIGITS(4)) a_if ();
    debug_display_scan_if #(.DATA_W(20), .NUM_CH(3), .NUM_DIGITS(4)) b_if ();

    debug_display_scan #(
        .DATA_W(32), .NUM_CH(4), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK(1)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a_n),
        .bus   (a_if.slave)
    );

    debug_display_scan #(
        .DATA_W(20), .NUM_CH(3), .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK(1)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b_n),
        .bus   (b_if.slave)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] anode_of(input bit use_b);
        return use_b ? b_if.sseg_anode : a_if.sseg_anode;
    endfunction

    // Waits for the next blank cycle, then for the slot with the requested anode.
    task automatic wait_slot(input bit use_b, input logic [3:0] exp, input string tag);
        int n;
        n = 0;
        while (anode_of(use_b) !== 4'hF && n < 40) begin tick(1); n++; end
        check({tag, "_blank"}, anode_of(use_b), 4'hF);
        n = 0;
        while (anode_of(use_b) !== exp && n < 40) begin tick(1); n++; end
        check({tag, "_anode"}, anode_of(use_b), exp);
    endtask

    task automatic pulse_a();
        a_if.page_step = 1'b1;
        tick(1);
        a_if.page_step = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        a_if.ch_data = {32'h0F1E_2D3C, 32'hA5C3_9E0F, 32'h0F1E_2D3C, 32'h1234_5678};
        a_if.ch_data[3*32 +: 32] = 32'hDEAD_BEEF;
        a_if.display_control = 2'd0;
        a_if.freeze = 1'b0;
        a_if.page_step = 1'b0;
        b_if.ch_data = {20'h6789F, 20'h12345, 20'hABCDE};
        b_if.display_control = 2'd1;
        b_if.freeze = 1'b0;
        b_if.page_step = 1'b0;

        // Reset state
        tick(5);
        check("rst_anode", a_if.sseg_anode, 4'hF);
        check("rst_cathode", a_if.sseg_cathode, 7'h7F);
        check("rst_dp", a_if.sseg_dp, 1'b1);
        check("rst_page", a_if.cur_page, 1'b0);

        // First slot: blank at cnt 0, digit 0 lit from cnt 1 with one clk register delay
        rst_a_n = 1'b1;
        tick(1);
        check("first_blank", a_if.sseg_anode, 4'hF);
        tick(1);
        check("d0_anode", a_if.sseg_anode, 4'hE);
        check("d0_cathode", a_if.sseg_cathode, 7'h00);
        tick(3);
        check("gap_blank", a_if.sseg_anode, 4'hF);
        check("gap_cathode", a_if.sseg_cathode, 7'h7F);
        tick(1);
        check("d1_anode", a_if.sseg_anode, 4'hD);
        check("d1_cathode", a_if.sseg_cathode, 7'h78);
        tick(4);
        check("d2_anode", a_if.sseg_anode, 4'hB);
        check("d2_cathode", a_if.sseg_cathode, 7'h02);
        tick(4);
        check("d3_anode", a_if.sseg_anode, 4'h7);
        check("d3_cathode", a_if.sseg_cathode, 7'h12);
        check("d3_dp_off", a_if.sseg_dp, 1'b1);
        tick(4);
        check("wrap_anode", a_if.sseg_anode, 4'hE);

        // Paging
        pulse_a();
        check("page1", a_if.cur_page, 1'b1);
        wait_slot(1'b0, 4'hE, "p1d0");
        check("p1d0_cathode", a_if.sseg_cathode, 7'h19);
        wait_slot(1'b0, 4'hD, "p1d1");
        check("p1d1_cathode", a_if.sseg_cathode, 7'h30);
        wait_slot(1'b0, 4'h7, "p1d3");
        check("p1d3_cathode", a_if.sseg_cathode, 7'h79);
        pulse_a();
        check("page_wrap", a_if.cur_page, 1'b0);
        a_if.page_step = 1'b1;
        tick(10);
        check("step_held", a_if.cur_page, 1'b1);
        a_if.page_step = 1'b0;
        tick(1);
        check("step_release", a_if.cur_page, 1'b1);

        // Freeze
        a_if.freeze = 1'b1;
        tick(1);
        a_if.ch_data[31:0] = 32'hFFFF_FFFF;
        a_if.display_control = 2'd2;
        wait_slot(1'b0, 4'hE, "frz_d0");
        check("frz_d0_cathode", a_if.sseg_cathode, 7'h19);
        check("frz_d0_dp", a_if.sseg_dp, 1'b1);
        check("frz_page", a_if.cur_page, 1'b1);
        wait_slot(1'b0, 4'h7, "frz_d3");
        check("frz_d3_cathode", a_if.sseg_cathode, 7'h79);
        check("frz_d3_dp", a_if.sseg_dp, 1'b0);
        a_if.freeze = 1'b0;
        tick(1);
        check("unfrz_page", a_if.cur_page, 1'b0);
        wait_slot(1'b0, 4'hE, "ch2_d0");
        check("ch2_d0_cathode", a_if.sseg_cathode, 7'h0E);
        wait_slot(1'b0, 4'hB, "ch2_d2");
        check("ch2_d2_cathode", a_if.sseg_cathode, 7'h06);
        check("ch2_dp", a_if.sseg_dp, 1'b1);

        // Channel change beats a simultaneous step edge
        pulse_a();
        check("pre_chg_page", a_if.cur_page, 1'b1);
        a_if.display_control = 2'd1;
        a_if.page_step = 1'b1;
        tick(1);
        check("chg_step_page", a_if.cur_page, 1'b0);
        a_if.page_step = 1'b0;
        tick(1);
        check("chg_step_hold", a_if.cur_page, 1'b0);
        wait_slot(1'b0, 4'hE, "ch1_d0");
        check("ch1_d0_cathode", a_if.sseg_cathode, 7'h46);

        // 20-bit build: partial page, out-of-range select, reset mid-slot
        check("b_rst_anode", b_if.sseg_anode, 4'hF);
        rst_b_n = 1'b1;
        tick(1);
        check("b_first_blank", b_if.sseg_anode, 4'hF);
        tick(1);
        check("b_d0_anode", b_if.sseg_anode, 4'hE);
        check("b_d0_cathode", b_if.sseg_cathode, 7'h12);
        b_if.page_step = 1'b1;
        tick(1);
        b_if.page_step = 1'b0;
        tick(1);
        check("b_page1", b_if.cur_page, 1'b1);
        wait_slot(1'b1, 4'hE, "b_p1d0");
        check("b_p1d0_cathode", b_if.sseg_cathode, 7'h79);
        wait_slot(1'b1, 4'hD, "b_p1d1");
        check("b_p1d1_cathode", b_if.sseg_cathode, 7'h40);
        wait_slot(1'b1, 4'h7, "b_p1d3");
        check("b_p1d3_cathode", b_if.sseg_cathode, 7'h40);
        b_if.display_control = 2'd3;
        tick(1);
        check("b_oor_page", b_if.cur_page, 1'b0);
        wait_slot(1'b1, 4'hE, "b_oor_d0");
        check("b_oor_d0_cathode", b_if.sseg_cathode, 7'h06);
        wait_slot(1'b1, 4'hD, "b_oor_d1");
        check("b_oor_d1_cathode", b_if.sseg_cathode, 7'h21);
        wait_slot(1'b1, 4'hB, "b_mid");
        tick(1);
        rst_b_n = 1'b0;
        #1;
        check("b_async_anode", b_if.sseg_anode, 4'hF);
        check("b_async_cathode", b_if.sseg_cathode, 7'h7F);
        tick(2);
        check("b_rst_hold", b_if.sseg_anode, 4'hF);
        rst_b_n = 1'b1;
        tick(1);
        check("b_restart_blank", b_if.sseg_anode, 4'hF);
        tick(1);
        check("b_restart_anode", b_if.sseg_anode, 4'hE);
        check("b_restart_cathode", b_if.sseg_cathode, 7'h06);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
